// File: rtl/operand_packer_pkg.sv
// Shared types for the operand packer: element type, operand kinds,
// FSM state encoding and small elaboration-time helpers.
package operand_packer_pkg;

  localparam int DATA_TYPE_SIZE = 16;

  typedef logic [DATA_TYPE_SIZE-1:0] data_type;

  typedef enum logic [1:0] {
    OP_ACT    = 2'd0,
    OP_WEIGHT = 2'd1,
    OP_OFFSET = 2'd2,
    OP_RSVD   = 2'd3
  } operand_kind_t;

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_PUSH = 1'b1
  } pack_state_t;

  // Larger of two elaboration-time integers (pack register lane count).
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/operand_packer_if.sv
// Bundle of the element stream, the three row-wide FIFO write ports and the
// status lines between operand_packer and its neighbours.
interface operand_packer_if
  import operand_packer_pkg::*;
#(
  parameter int SYSTOL_ACTIVATION_COUNT = 16,
  parameter int SYSTOL_WEIGHT_COUNT     = 16
) ();

  logic                                   cu_rst_busy_i;

  data_type                               s_data_i;
  operand_kind_t                          s_kind_i;
  logic                                   s_valid_i;
  logic                                   s_ready_o;

  data_type [0:SYSTOL_ACTIVATION_COUNT-1] activation_o;
  logic                                   activation_wr_en_o;
  logic                                   activation_full_i;

  data_type [0:SYSTOL_WEIGHT_COUNT-1]     weight_o;
  logic                                   weight_wr_en_o;
  logic                                   weight_full_i;

  data_type [0:SYSTOL_WEIGHT_COUNT-1]     offset_o;
  logic                                   offset_wr_en_o;
  logic                                   offset_full_i;

  logic                                   weight_update_o;
  logic                                   error_o;

  // Packer side: consumes the stream, drives the FIFO writes.
  modport master (
    input  cu_rst_busy_i,
    input  s_data_i, s_kind_i, s_valid_i,
    output s_ready_o,
    output activation_o, activation_wr_en_o,
    input  activation_full_i,
    output weight_o, weight_wr_en_o,
    input  weight_full_i,
    output offset_o, offset_wr_en_o,
    input  offset_full_i,
    output weight_update_o, error_o
  );

  // Environment side: stream source plus computing_unit FIFOs.
  modport slave (
    output cu_rst_busy_i,
    output s_data_i, s_kind_i, s_valid_i,
    input  s_ready_o,
    input  activation_o, activation_wr_en_o,
    output activation_full_i,
    input  weight_o, weight_wr_en_o,
    output weight_full_i,
    input  offset_o, offset_wr_en_o,
    output offset_full_i,
    input  weight_update_o, error_o
  );

endinterface

// File: rtl/operand_packer_row_packer.sv
// Lane register with write-lane counter. Each write stores one element at
// the current lane; the counter wraps to 0 after the lane len-1 write.
module row_packer
  import operand_packer_pkg::*;
#(
  parameter int MAX_LANES = 16,
  parameter int CW        = $clog2(MAX_LANES + 1)
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       i_wr,
  input  data_type                   i_data,
  input  logic [CW-1:0]              i_len,
  output logic [CW-1:0]              o_lane_ctr,
  output logic                       o_last,
  output data_type [0:MAX_LANES-1]   o_lanes
);

  logic [CW-1:0]             r_lane_ctr;
  data_type [0:MAX_LANES-1]  r_lanes;

  assign o_last     = (r_lane_ctr == (i_len - CW'(1)));
  assign o_lane_ctr = r_lane_ctr;
  assign o_lanes    = r_lanes;

  // Advance the write lane per stored element, wrapping at the row end.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_lane_ctr <= {CW{1'b0}};
    end else if (i_wr) begin
      r_lane_ctr <= o_last ? {CW{1'b0}} : (r_lane_ctr + CW'(1));
    end
  end

  // Store the incoming element into the lane selected by the counter.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_lanes <= '0;
    end else if (i_wr) begin
      for (int i = 0; i < MAX_LANES; i++) begin
        if (r_lane_ctr == CW'(i)) begin
          r_lanes[i] <= i_data;
        end
      end
    end
  end

endmodule

// File: rtl/operand_packer.sv
// Packs a narrow tagged element stream into full activation / weight /
// offset rows and writes each row into the matching computing_unit FIFO.
// Emits a one-cycle weight_update after every complete weight tile.
module operand_packer
  import operand_packer_pkg::*;
#(
  parameter int SYSTOL_ACTIVATION_COUNT = 16,
  parameter int SYSTOL_WEIGHT_COUNT     = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  operand_packer_if.master bus
);

  localparam int MAX_LANES = max_int(SYSTOL_ACTIVATION_COUNT, SYSTOL_WEIGHT_COUNT);
  localparam int CW        = $clog2(MAX_LANES + 1);
  localparam int TW        = (SYSTOL_ACTIVATION_COUNT > 1) ? $clog2(SYSTOL_ACTIVATION_COUNT) : 1;

  pack_state_t               r_state;
  pack_state_t               w_next_state;
  operand_kind_t             r_row_kind;
  logic [TW-1:0]             r_tile_ctr;
  logic                      r_weight_update;
  logic                      r_error;

  logic [CW-1:0]             w_lane_ctr;
  logic                      w_last;
  data_type [0:MAX_LANES-1]  w_lanes;

  logic                      w_row_active;
  operand_kind_t             w_eff_kind;
  logic [CW-1:0]             w_len;
  logic                      w_kind_ok;
  logic                      w_accept;
  logic                      w_good;
  logic                      w_bad;
  logic                      w_sel_full;
  logic                      w_push;
  logic                      w_s_ready;
  logic                      w_act_wr;
  logic                      w_wgt_wr;
  logic                      w_off_wr;
  logic                      w_tile_last;

  // A row is in progress once its first element has been stored; the row
  // kind register is only meaningful from then on (and through PUSH).
  assign w_row_active = (w_lane_ctr != {CW{1'b0}});
  assign w_eff_kind   = w_row_active ? r_row_kind : bus.s_kind_i;
  assign w_len        = (w_eff_kind == OP_ACT) ? CW'(SYSTOL_ACTIVATION_COUNT)
                                               : CW'(SYSTOL_WEIGHT_COUNT);

  // Reserved beats and mid-row kind changes are consumed but never stored.
  assign w_kind_ok = (bus.s_kind_i != OP_RSVD) &&
                     (!w_row_active || (bus.s_kind_i == r_row_kind));
  assign w_accept  = bus.s_valid_i & w_s_ready;
  assign w_good    = w_accept & w_kind_ok;
  assign w_bad     = w_accept & ~w_kind_ok;

  assign w_tile_last = (r_tile_ctr == TW'(SYSTOL_ACTIVATION_COUNT - 1));

  row_packer #(
    .MAX_LANES (MAX_LANES),
    .CW        (CW)
  ) u_row_packer (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .i_wr       (w_good),
    .i_data     (bus.s_data_i),
    .i_len      (w_len),
    .o_lane_ctr (w_lane_ctr),
    .o_last     (w_last),
    .o_lanes    (w_lanes)
  );

  // Full flag of the FIFO the current row is destined for.
  always_comb begin
    case (r_row_kind)
      OP_ACT:    w_sel_full = bus.activation_full_i;
      OP_WEIGHT: w_sel_full = bus.weight_full_i;
      OP_OFFSET: w_sel_full = bus.offset_full_i;
      default:   w_sel_full = 1'b1;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= ST_FILL;
    end else begin
      r_state <= w_next_state;
    end
  end

  // FSM next state: leave FILL on the last stored element, leave PUSH on the write.
  always_comb begin
    case (r_state)
      ST_FILL: begin
        if (w_good && w_last) begin
          w_next_state = ST_PUSH;
        end else begin
          w_next_state = ST_FILL;
        end
      end
      ST_PUSH: begin
        if (w_push) begin
          w_next_state = ST_FILL;
        end else begin
          w_next_state = ST_PUSH;
        end
      end
      default: w_next_state = ST_FILL;
    endcase
  end

  // FSM outputs: stream ready in FILL, kind-routed FIFO write in PUSH.
  always_comb begin
    w_s_ready = 1'b0;
    w_push    = 1'b0;
    w_act_wr  = 1'b0;
    w_wgt_wr  = 1'b0;
    w_off_wr  = 1'b0;
    case (r_state)
      ST_FILL: begin
        w_s_ready = rst_i & ~bus.cu_rst_busy_i;
      end
      ST_PUSH: begin
        w_push = ~w_sel_full & ~bus.cu_rst_busy_i;
        case (r_row_kind)
          OP_ACT:    w_act_wr = w_push;
          OP_WEIGHT: w_wgt_wr = w_push;
          OP_OFFSET: w_off_wr = w_push;
          default:   w_act_wr = 1'b0;
        endcase
      end
      default: begin
        w_s_ready = 1'b0;
      end
    endcase
  end

  // Capture the kind of a row on its first stored element.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_row_kind <= OP_ACT;
    end else if (w_good && !w_row_active) begin
      r_row_kind <= bus.s_kind_i;
    end
  end

  // Count weight rows per tile and flag the tile-completing push one cycle later.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_tile_ctr      <= {TW{1'b0}};
      r_weight_update <= 1'b0;
    end else begin
      r_weight_update <= 1'b0;
      if (w_wgt_wr) begin
        if (w_tile_last) begin
          r_tile_ctr      <= {TW{1'b0}};
          r_weight_update <= 1'b1;
        end else begin
          r_tile_ctr <= r_tile_ctr + TW'(1);
        end
      end
    end
  end

  // Sticky protocol error, cleared only by reset.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_error <= 1'b0;
    end else if (w_bad) begin
      r_error <= 1'b1;
    end
  end

  assign bus.s_ready_o          = w_s_ready;
  assign bus.activation_o       = w_lanes[0:SYSTOL_ACTIVATION_COUNT-1];
  assign bus.weight_o           = w_lanes[0:SYSTOL_WEIGHT_COUNT-1];
  assign bus.offset_o           = w_lanes[0:SYSTOL_WEIGHT_COUNT-1];
  assign bus.activation_wr_en_o = w_act_wr;
  assign bus.weight_wr_en_o     = w_wgt_wr;
  assign bus.offset_wr_en_o     = w_off_wr;
  assign bus.weight_update_o    = r_weight_update;
  assign bus.error_o            = r_error;

endmodule

// File: tb/tb_operand_packer.sv
// Scoreboard bench for operand_packer (4x4 configuration): a row-level
// reference model predicts each FIFO write; a monitor checks every write.
module tb_operand_packer;
  import operand_packer_pkg::*;

  localparam int NA = 4;
  localparam int NW = 4;

  typedef struct packed {
    logic [1:0]  kind;
    logic [63:0] data;
    logic        wupd;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  exp_t        sb[$];
  logic [15:0] mrow[$];
  logic [1:0]  mkind = 2'd0;
  int          wrows = 0;
  logic        exp_err = 1'b0;
  bit          rand_en = 1'b0;
  logic        exp_wupd = 1'b0;
  int          wupd_count = 0;
  int          wr_count[3] = '{0, 0, 0};

  operand_packer_if #(.SYSTOL_ACTIVATION_COUNT(NA), .SYSTOL_WEIGHT_COUNT(NW)) bus ();

  operand_packer #(.SYSTOL_ACTIVATION_COUNT(NA), .SYSTOL_WEIGHT_COUNT(NW)) dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Reference model: apply one accepted beat at row level.
  task automatic model_beat(input logic [1:0] k, input logic [15:0] d);
    exp_t e;
    int   len;
    if (k == 2'd3) begin
      exp_err = 1'b1;
      return;
    end
    if (mrow.size() == 0) mkind = k;
    else if (k != mkind) begin
      exp_err = 1'b1;
      return;
    end
    mrow.push_back(d);
    len = (mkind == 2'd0) ? NA : NW;
    if (mrow.size() == len) begin
      e.kind = mkind;
      e.data = 64'd0;
      for (int i = 0; i < len; i++) e.data = e.data | (64'(mrow[i]) << (16 * (len - 1 - i)));
      e.wupd = 1'b0;
      if (mkind == 2'd1) begin
        wrows++;
        e.wupd = ((wrows % NA) == 0);
      end
      sb.push_back(e);
      mrow.delete();
    end
  endtask

  task automatic model_reset();
    mrow.delete();
    sb.delete();
    wrows = 0;
    exp_err = 1'b0;
  endtask

  // Advance one cycle; inputs change just after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_en) begin
      bus.activation_full_i = ($urandom_range(0, 3) == 0);
      bus.weight_full_i     = ($urandom_range(0, 3) == 0);
      bus.offset_full_i     = ($urandom_range(0, 3) == 0);
      bus.cu_rst_busy_i     = ($urandom_range(0, 9) == 0);
    end
  endtask

  task automatic send(input logic [1:0] k, input logic [15:0] d);
    bit got = 1'b0;
    bus.s_valid_i = 1'b1;
    bus.s_kind_i  = operand_kind_t'(k);
    bus.s_data_i  = d;
    for (int c = 0; c < 200 && !got; c++) begin
      @(negedge clk);
      if (bus.s_ready_o) begin
        got = 1'b1;
        model_beat(k, d);
      end
      tick();
    end
    bus.s_valid_i = 1'b0;
    if (!got) check("beat_accept_timeout", 64'd0, 64'd1);
    else      check("error_o", 64'(bus.error_o), 64'(exp_err));
  endtask

  // Monitor: pops the scoreboard on every FIFO write.
  initial begin : monitor
    exp_t        e;
    int          n;
    int          k;
    logic [63:0] act;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        n = int'(bus.activation_wr_en_o) + int'(bus.weight_wr_en_o) + int'(bus.offset_wr_en_o);
        if (exp_wupd || bus.weight_update_o)
          check("weight_update", 64'(bus.weight_update_o), 64'(exp_wupd));
        if (bus.weight_update_o) wupd_count++;
        exp_wupd = 1'b0;
        if (n > 1) begin
          check("single_wr_en", 64'(n), 64'd1);
        end else if (n == 1) begin
          k = bus.activation_wr_en_o ? 0 : (bus.weight_wr_en_o ? 1 : 2);
          act = (k == 0) ? 64'(bus.activation_o) : ((k == 1) ? 64'(bus.weight_o) : 64'(bus.offset_o));
          if (sb.size() == 0) begin
            check("unexpected_write", 64'(k), 64'hdead);
          end else begin
            e = sb.pop_front();
            check("wr_kind", 64'(k), 64'(e.kind));
            check("wr_data", act, e.data);
            exp_wupd = e.wupd;
            wr_count[k]++;
          end
        end
      end else begin
        exp_wupd = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int          w0;
    int          kk;
    logic [1:0]  rk;
    bus.cu_rst_busy_i     = 1'b0;
    bus.s_data_i          = 16'd0;
    bus.s_kind_i          = OP_ACT;
    bus.s_valid_i         = 1'b0;
    bus.activation_full_i = 1'b0;
    bus.weight_full_i     = 1'b0;
    bus.offset_full_i     = 1'b0;

    // Reset state
    bus.s_valid_i = 1'b1;
    #12;
    check("rst_s_ready", 64'(bus.s_ready_o), 64'd0);
    check("rst_wr_en", {61'd0, bus.activation_wr_en_o, bus.weight_wr_en_o, bus.offset_wr_en_o}, 64'd0);
    check("rst_act_data", 64'(bus.activation_o), 64'd0);
    check("rst_error", 64'(bus.error_o), 64'd0);
    check("rst_wupd", 64'(bus.weight_update_o), 64'd0);
    bus.s_valid_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    @(negedge clk);
    check("idle_s_ready", 64'(bus.s_ready_o), 64'd1);
    tick();

    // Activation row, back-to-back
    for (int i = 1; i <= 4; i++) send(2'd0, 16'(i));
    @(negedge clk);
    check("act_wr_en_after_last", 64'(bus.activation_wr_en_o), 64'd1);
    check("act_push_ready_low", 64'(bus.s_ready_o), 64'd0);
    check("act_data", 64'(bus.activation_o), 64'h0001_0002_0003_0004);
    tick();
    @(negedge clk);
    check("act_ready_back", 64'(bus.s_ready_o), 64'd1);
    tick();

    // Weight tile plus one extra row
    wupd_count = 0;
    w0 = wr_count[1];
    for (int i = 0; i < 20; i++) send(2'd1, 16'(16'h100 + i));
    repeat (4) tick();
    check("tile_wupd_count", 64'(wupd_count), 64'd1);
    check("tile_weight_writes", 64'(wr_count[1] - w0), 64'd5);

    // Offset backpressure, 5 cycles
    bus.offset_full_i = 1'b1;
    for (int i = 0; i < 4; i++) send(2'd2, 16'(41 + i));
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("bp_no_write", 64'(bus.offset_wr_en_o), 64'd0);
      check("bp_ready_low", 64'(bus.s_ready_o), 64'd0);
      check("bp_data_stable", 64'(bus.offset_o), 64'h0029_002a_002b_002c);
      tick();
    end
    bus.offset_full_i = 1'b0;
    w0 = wr_count[2];
    @(negedge clk);
    check("bp_write_released", 64'(bus.offset_wr_en_o), 64'd1);
    tick();
    @(negedge clk);
    check("bp_single_write", 64'(bus.offset_wr_en_o), 64'd0);
    tick();
    check("bp_write_count", 64'(wr_count[2] - w0), 64'd1);

    // Kind error mid-row
    send(2'd1, 16'd10);
    send(2'd1, 16'd11);
    send(2'd0, 16'd99);
    send(2'd1, 16'd12);
    send(2'd1, 16'd13);
    repeat (6) tick();
    check("error_sticky", 64'(bus.error_o), 64'd1);

    // Mid-row asynchronous reset
    send(2'd0, 16'd21);
    send(2'd0, 16'd22);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("mrst_s_ready", 64'(bus.s_ready_o), 64'd0);
    check("mrst_wr_en", {61'd0, bus.activation_wr_en_o, bus.weight_wr_en_o, bus.offset_wr_en_o}, 64'd0);
    check("mrst_error", 64'(bus.error_o), 64'd0);
    check("mrst_act_data", 64'(bus.activation_o), 64'd0);
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 5; i <= 8; i++) send(2'd0, 16'(i));
    repeat (3) tick();
    check("mrst_fresh_row_written", 64'(sb.size()), 64'd0);

    // cu_rst_busy during FILL
    send(2'd0, 16'd31);
    send(2'd0, 16'd32);
    bus.cu_rst_busy_i = 1'b1;
    bus.s_valid_i = 1'b1;
    bus.s_kind_i  = OP_ACT;
    bus.s_data_i  = 16'd77;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("busy_ready_low", 64'(bus.s_ready_o), 64'd0);
      tick();
    end
    bus.s_valid_i = 1'b0;
    bus.cu_rst_busy_i = 1'b0;
    send(2'd0, 16'd33);
    send(2'd0, 16'd34);
    repeat (3) tick();

    // Randomized traffic with random full/busy
    rand_en = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if (mrow.size() != 0 && $urandom_range(0, 9) < 9) rk = mkind;
      else begin
        kk = ($urandom_range(0, 19) == 0) ? 3 : int'($urandom_range(0, 2));
        rk = 2'(kk);
      end
      send(rk, 16'($urandom));
    end
    rand_en = 1'b0;
    bus.activation_full_i = 1'b0;
    bus.weight_full_i     = 1'b0;
    bus.offset_full_i     = 1'b0;
    bus.cu_rst_busy_i     = 1'b0;
    repeat (20) tick();
    check("sb_drained", 64'(sb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
